// File: rtl/mac_pkg.sv
// Shared types and default parameters for the MAC accumulator datapath.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        DONE
    } mac_state_t;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_ACC_WIDTH = 16;
    localparam int unsigned DEF_LEN       = 8;

endpackage

// File: rtl/mac_accumulator_if.sv
// Operand-in / result-out valid-ready bundle for mac_accumulator.
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic                 out_ovf;

    // Operand source and result sink side.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );

endinterface

// File: rtl/multiplier_csa.sv
// Unsigned 4x4 multiplier: four partial products reduced by two carry-save
// stages and one final carry-propagate add.
module multiplier_csa
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);

    localparam int unsigned PW = 2 * WIDTH;

    if (WIDTH != 4) begin : g_width_chk
        $error("multiplier_csa: WIDTH must be 4");
    end

    logic [PW-1:0] pp0, pp1, pp2, pp3;
    logic [PW-1:0] s1, c1, s2, c2;

    // Partial products, CSA reduction 4 -> 2, then final add.
    always_comb begin
        pp0 = b_i[0] ? PW'(a_i)        : '0;
        pp1 = b_i[1] ? (PW'(a_i) << 1) : '0;
        pp2 = b_i[2] ? (PW'(a_i) << 2) : '0;
        pp3 = b_i[3] ? (PW'(a_i) << 3) : '0;
        s1  = pp0 ^ pp1 ^ pp2;
        c1  = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
        s2  = s1 ^ c1 ^ pp3;
        c2  = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
        p_o = s2 + c2;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate of LEN operand pairs per result, saturating unsigned
// accumulator with a sticky overflow flag, valid/ready on both sides.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned LEN       = DEF_LEN
) (
    input logic          clk,
    input logic          rst,
    mac_accumulator_if.slave mac_if
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(LEN + 1);

    if (WIDTH != 4) begin : g_width_chk
        $error("mac_accumulator: WIDTH must be 4");
    end
    if (ACC_WIDTH < 2 * WIDTH) begin : g_acc_chk
        $error("mac_accumulator: ACC_WIDTH must be >= 2*WIDTH");
    end
    if (LEN < 1) begin : g_len_chk
        $error("mac_accumulator: LEN must be >= 1");
    end

    mac_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic                 prod_v_q, prod_v_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept;
    logic [PW-1:0]        mul_p;

    multiplier_csa #(
        .WIDTH(WIDTH)
    ) u_mul (
        .a_i(mac_if.in_a),
        .b_i(mac_if.in_b),
        .p_o(mul_p)
    );

    // Next state: product capture, saturating add, batch sequencing.
    always_comb begin
        accept   = mac_if.in_valid && (state_q == ACCUM);
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        prod_v_d = accept;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        sum      = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_q);

        if (accept) begin
            prod_d = mul_p;
            cnt_d  = cnt_q + CW'(1);
        end

        if (prod_v_q) begin
            if (sum[ACC_WIDTH]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
            end
        end

        unique case (state_q)
            ACCUM: begin
                if (accept && (cnt_q == CW'(LEN - 1))) begin
                    state_d = DRAIN;
                end
            end
            // The last product lands in acc on the edge leaving DRAIN.
            DRAIN: state_d = DONE;
            DONE: begin
                if (mac_if.out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers; reset discards any partial batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCUM;
            cnt_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    assign mac_if.in_ready  = (state_q == ACCUM);
    assign mac_if.out_valid = (state_q == DONE);
    assign mac_if.out_acc   = acc_q;
    assign mac_if.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a default instance, an 8-bit-accumulator shadow
// fed the same stimulus, and a LEN=1 instance.
module tb_mac_accumulator;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_accumulator_if #(.WIDTH(4), .ACC_WIDTH(16)) if0 ();
    mac_accumulator_if #(.WIDTH(4), .ACC_WIDTH(8))  if1 ();
    mac_accumulator_if #(.WIDTH(4), .ACC_WIDTH(16)) if2 ();

    // The narrow instance sees exactly the default instance's stimulus.
    assign if1.in_valid  = if0.in_valid;
    assign if1.in_a      = if0.in_a;
    assign if1.in_b      = if0.in_b;
    assign if1.out_ready = if0.out_ready;

    mac_accumulator #(.WIDTH(4), .ACC_WIDTH(16), .LEN(8)) dut (
        .clk(clk), .rst(rst), .mac_if(if0)
    );
    mac_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .LEN(8)) dut_narrow (
        .clk(clk), .rst(rst), .mac_if(if1)
    );
    mac_accumulator #(.WIDTH(4), .ACC_WIDTH(16), .LEN(1)) dut_len1 (
        .clk(clk), .rst(rst), .mac_if(if2)
    );

    int n_total = 0;
    int n_bad   = 0;
    int hs_cnt  = 0;
    int unsigned op_a[$];
    int unsigned op_b[$];
    int unsigned prods[$];

    // Handshakes of the default instance, seen half a cycle before their edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && if0.in_valid === 1'b1 && if0.in_ready === 1'b1) hs_cnt++;
    end

    // Reference: saturating sum of the accepted products of this batch.
    function automatic void model(input int unsigned w, output longint unsigned acc,
                                  output bit ovf);
        longint unsigned lim;
        lim = (64'd1 << w) - 64'd1;
        acc = 0;
        ovf = 1'b0;
        foreach (prods[i]) begin
            if (acc + longint'(prods[i]) > lim) begin
                acc = lim;
                ovf = 1'b1;
            end else begin
                acc = acc + longint'(prods[i]);
            end
        end
    endfunction

    task automatic load_ops(input int unsigned a_base, input int unsigned a_step,
                            input int unsigned b);
        for (int i = 0; i < 8; i++) begin
            op_a.push_back(a_base + a_step * i);
            op_b.push_back(b);
        end
    endtask

    task automatic drive_noise();
        if0.in_valid = 1'($urandom_range(1));
        if0.in_a     = 4'($urandom);
        if0.in_b     = 4'($urandom);
    endtask

    // Present queued pairs; returns just after the edge that takes the last one.
    task automatic feed(input int unsigned gap_pct);
        int unsigned cycles = 0;
        while (op_a.size() != 0 && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            if ($urandom_range(99) < gap_pct) begin
                if0.in_valid = 1'b0;
                if0.in_a     = 4'($urandom);
                if0.in_b     = 4'($urandom);
            end else begin
                if0.in_valid = 1'b1;
                if0.in_a     = 4'(op_a[0]);
                if0.in_b     = 4'(op_b[0]);
            end
            @(negedge clk);
            if (if0.in_valid === 1'b1 && if0.in_ready === 1'b1) begin
                prods.push_back(op_a[0] * op_b[0]);
                void'(op_a.pop_front());
                void'(op_b.pop_front());
            end
        end
        n_total++;
        if (op_a.size() != 0) begin
            n_bad++;
            $display("FAIL feed_budget: pairs left %0d, required 0", op_a.size());
            op_a.delete();
            op_b.delete();
        end
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
    endtask

    // Wait for out_valid and compare both accumulator widths with the model.
    task automatic check_result(input string name, input bit noise, input bit chk_lat);
        longint unsigned e16, e8;
        bit o16, o8;
        int lat = 0;
        model(16, e16, o16);
        model(8, e8, o8);
        if (noise) drive_noise();
        do begin
            @(negedge clk);
            lat++;
            if (if0.out_valid === 1'b1) break;
            @(posedge clk);
            #1;
            if (noise) drive_noise();
        end while (lat < 40);
        n_total++;
        if (if0.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_valid: out_valid %b after %0d cycles, required 1", name,
                     if0.out_valid, lat);
        end
        if (chk_lat) begin
            n_total++;
            if (lat != 2) begin
                n_bad++;
                $display("FAIL %s_latency: %0d cycles, required 2", name, lat);
            end
        end
        n_total++;
        if (if0.out_acc !== 16'(e16)) begin
            n_bad++;
            $display("FAIL %s_acc: got %0d, required %0d", name, if0.out_acc, e16);
        end
        n_total++;
        if (if0.out_ovf !== o16) begin
            n_bad++;
            $display("FAIL %s_ovf: got %b, required %b", name, if0.out_ovf, o16);
        end
        n_total++;
        if (if1.out_acc !== 8'(e8)) begin
            n_bad++;
            $display("FAIL %s_acc8: got %0d, required %0d", name, if1.out_acc, e8);
        end
        n_total++;
        if (if1.out_ovf !== o8) begin
            n_bad++;
            $display("FAIL %s_ovf8: got %b, required %b", name, if1.out_ovf, o8);
        end
    endtask

    // With out_ready high the result is taken on the next edge and everything clears.
    task automatic finish_handshake(input string name);
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_release: valid/ready %b/%b, required 0/1", name,
                     if0.out_valid, if0.in_ready);
        end
        n_total++;
        if (if0.out_acc !== 16'd0 || if0.out_ovf !== 1'b0 || if1.out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_clear: acc %0d ovf %b ovf8 %b, required 0 0 0", name,
                     if0.out_acc, if0.out_ovf, if1.out_ovf);
        end
        prods.delete();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        if0.in_valid  = 1'b0;
        if0.in_a      = '0;
        if0.in_b      = '0;
        if0.out_ready = 1'b1;
        if2.in_valid  = 1'b0;
        if2.in_a      = '0;
        if2.in_b      = '0;
        if2.out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hs: valid/ready %b/%b, required 0/1", if0.out_valid,
                     if0.in_ready);
        end
        n_total++;
        if (if0.out_acc !== 16'd0 || if0.out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_acc: acc %0d ovf %b, required 0 0", if0.out_acc, if0.out_ovf);
        end
        n_total++;
        if (if2.out_valid !== 1'b0 || if2.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_len1: valid/ready %b/%b, required 0/1", if2.out_valid,
                     if2.in_ready);
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_basic();
        load_ops(1, 1, 3);
        feed(0);
        check_result("basic", 1'b0, 1'b1);
        finish_handshake("basic");
    endtask

    task automatic test_saturate();
        load_ops(15, 0, 15);
        feed(0);
        check_result("sat", 1'b0, 1'b1);
        finish_handshake("sat");
    endtask

    task automatic test_backpressure();
        int hs0;
        longint unsigned e16;
        bit o16;
        if0.out_ready = 1'b0;
        load_ops(1, 1, 3);
        feed(0);
        check_result("stall", 1'b0, 1'b1);
        model(16, e16, o16);
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if0.in_valid = 1'b1;
            if0.in_a     = 4'($urandom);
            if0.in_b     = 4'($urandom);
            @(negedge clk);
            n_total++;
            if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hs: valid/ready %b/%b, required 1/0", if0.out_valid,
                         if0.in_ready);
            end
            n_total++;
            if (if0.out_acc !== 16'(e16) || if0.out_ovf !== o16) begin
                n_bad++;
                $display("FAIL stall_hold: acc %0d ovf %b, required %0d %b", if0.out_acc,
                         if0.out_ovf, e16, o16);
            end
        end
        n_total++;
        if (hs_cnt != hs0) begin
            n_bad++;
            $display("FAIL stall_accepts: %0d, required 0", hs_cnt - hs0);
        end
        if0.out_ready = 1'b1;
        finish_handshake("stall");
        load_ops(1, 0, 1);
        feed(0);
        check_result("after_stall", 1'b0, 1'b1);
        finish_handshake("after_stall");
    endtask

    task automatic test_gaps();
        int hs0;
        for (int k = 0; k < 3; k++) begin
            hs0 = hs_cnt;
            load_ops(1, 1, 3);
            feed(50);
            check_result("gaps", 1'b1, 1'b1);
            finish_handshake("gaps");
            n_total++;
            if (hs_cnt - hs0 != 8) begin
                n_bad++;
                $display("FAIL gaps_accepts: %0d, required 8", hs_cnt - hs0);
            end
        end
    endtask

    task automatic test_random_ops();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                op_a.push_back($urandom_range(15));
                op_b.push_back($urandom_range(15));
            end
            feed(30);
            check_result("rand", 1'b1, 1'b1);
            finish_handshake("rand");
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            op_a.push_back(2);
            op_b.push_back(2);
        end
        feed(0);
        #2 rst = 1'b1;
        #1;
        prods.delete();
        n_total++;
        if (if0.out_acc !== 16'd0 || if0.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: acc %0d valid %b, required 0 0", if0.out_acc,
                     if0.out_valid);
        end
        #3 rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0 || if0.out_acc !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_release: ready %b valid %b acc %0d, required 1 0 0",
                     if0.in_ready, if0.out_valid, if0.out_acc);
        end
        load_ops(2, 0, 2);
        feed(0);
        check_result("rst_batch", 1'b0, 1'b1);
        finish_handshake("rst_batch");
    endtask

    task automatic test_len1();
        int unsigned a, b;
        int wait_cnt;
        a = 7;
        b = 9;
        if2.in_valid = 1'b1;
        if2.in_a     = 4'(a);
        if2.in_b     = 4'(b);
        for (int k = 0; k < 4; k++) begin
            wait_cnt = 0;
            do begin
                @(negedge clk);
                wait_cnt++;
            end while (if2.in_ready !== 1'b1 && wait_cnt < 6);
            n_total++;
            if (if2.in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL len1_ready: got %b, required 1", if2.in_ready);
            end
            @(negedge clk);
            n_total++;
            if (if2.in_ready !== 1'b0 || if2.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL len1_drain: ready/valid %b/%b, required 0/0", if2.in_ready,
                         if2.out_valid);
            end
            @(negedge clk);
            n_total++;
            if (if2.in_ready !== 1'b0 || if2.out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL len1_done: ready/valid %b/%b, required 0/1", if2.in_ready,
                         if2.out_valid);
            end
            n_total++;
            if (if2.out_acc !== 16'(a * b) || if2.out_ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL len1_acc: got %0d ovf %b, required %0d 0", if2.out_acc,
                         if2.out_ovf, a * b);
            end
            if (k >= 1) begin
                a = $urandom_range(15);
                b = $urandom_range(15);
            end
            if2.in_a = 4'(a);
            if2.in_b = 4'(b);
        end
        if2.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_gaps();
        test_random_ops();
        test_async_reset();
        test_len1();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
